fp_normalize_arbiter: RTL and testbench
=======================================

# fp_normalize_arbiter

Shared normalization engine for FPCore. It arbitrates up to NUM_REQ requesters (adder, multiplier, convert paths) onto one leading-zero-detect tree and left shifter. It returns each mantissa normalized, with its exponent adjusted and tagged with the requester index. It has a two-stage pipeline with valid/ready handshakes on both sides and sustains one result per cycle when not back-pressured.

## Interface
- WIDTH, 32: mantissa width; power of two, 8..64.
- EXP_WIDTH, 8: unsigned biased exponent width.
- NUM_REQ, 2: requester count, 2..4.
- TAG_WIDTH, $clog2(NUM_REQ): tag width.

Ports:
- aClock  in  1  clock; all logic is on the rising edge.
- aReset  in  1  reset; synchronous, active-high.
- aReqValid  in  NUM_REQ  per-requester request valid.
- aReqMantissa  in  NUM_REQ*WIDTH  packed mantissas; requester i occupies [i*WIDTH +: WIDTH].
- aReqExponent  in  NUM_REQ*EXP_WIDTH  packed exponents; same packing.
- anReqReady  out  NUM_REQ  one-hot or zero; high only for the granted requester when stage 1 can load.
- anOutValid  out  1  result valid.
- aOutReady  in  1  consumer ready.
- anOutMantissa  out  WIDTH  normalized mantissa.
- anOutExponent  out  EXP_WIDTH  adjusted exponent.
- anOutZero  out  1  input mantissa was zero.
- anOutTag  out  TAG_WIDTH  index of the originating requester.

## Operation
- **Transfer rules.** A requester transfer occurs when aReqValid[i] & anReqReady[i]. An output transfer occurs when anOutValid & aOutReady.
- **Requester obligations.** Requesters must not make aReqValid depend on anReqReady. Once valid is raised, it and its data stay stable until the transfer.
- **Arbitration.**
  - Round-robin with pointer rr (reset 0).
  - The grant goes to the first i with aReqValid[i] set, searching rr, rr+1, … modulo NUM_REQ.
  - On a transfer from i, rr becomes (i+1) mod NUM_REQ. Without a transfer, rr holds.
  - The grant is combinational from aReqValid and rr.
- **Stage 1 (S1).** Registers mantissa, exponent, tag and s1_valid. The internal LZD tree computes lzc (0..WIDTH) from the S1 mantissa.
- **Stage 1 compute, non-zero mantissa.**
  - If lzc < exponent: shift = lzc, new exponent = exponent - lzc.
  - Otherwise (underflow clamp): shift = exponent, new exponent = 0.
- **Stage 1 compute, zero mantissa (lzc = WIDTH).** Mantissa 0, exponent 0, zero flag 1.
- **Stage 2 (S2).** Registers the shifted mantissa (mantissa << shift, zero-filled), new exponent, zero flag, tag and s2_valid. anOut* are driven directly from the S2 registers.
- **Advance conditions.**
  - s2_load = s1_valid & (~s2_valid | aOutReady).
  - s1_load = grant_any & (~s1_valid | s2_load).
  - anReqReady[i] = grant[i] & (~s1_valid | s2_load).
- **Valid updates.**
  - s1_valid next = s1_load | (s1_valid & ~s2_load).
  - s2_valid next = s2_load | (s2_valid & ~aOutReady).
- **Arithmetic.** All exponent arithmetic is unsigned. The underflow rule guarantees no wrap. The shift amount is at most WIDTH-1 for non-zero inputs.

## Timing
- **Reset.** Takes effect on the first rising edge with aReset high.
  - s1_valid=0, s2_valid=0, rr=0.
  - anOutValid=0, anOutMantissa=0, anOutExponent=0, anOutZero=0, anOutTag=0.
  - anReqReady=0 while aReset is high.
- **Reset mid-operation.** In-flight S1/S2 contents are discarded with no output. Acceptance resumes on the first cycle after aReset falls.
- **Latency.** A transfer at edge T produces anOutValid high after edge T+1, so the result is visible in cycle T+2 relative to request presentation. Fixed latency is 2 cycles.
- **Throughput.** One transfer per cycle while aOutReady=1.
- **Full pipeline.** With aOutReady low, at most 2 items are held (S1 and S2) and anReqReady is all zero. When aOutReady rises, S2 drains and S1 advances in the same cycle, and a new request is accepted in that same cycle.
- **Held output.** While anOutValid & ~aOutReady, all anOut* hold stable.
- **Empty pipeline.** anOutValid=0; output data registers keep their last values, whose content is don't-care.
- **Simultaneous requests.** A requester that drops valid before its grant is never accepted, and rr does not move.

## Test plan
- **Single normalize.** Requester 0, WIDTH 32: mantissa 0x0000_1000, exponent 100 -> two cycles later, mantissa 0x8000_0000, exponent 81, zero 0, tag 0.
- **Underflow clamp.**
  - mantissa 0x0000_0001, exponent 10 -> mantissa 0x0000_0400, exponent 0.
  - mantissa 0x0000_0001, exponent 0 -> unchanged, exponent 0.
- **Zero input.** Mantissa 0, exponent 55 -> anOutZero 1, mantissa 0, exponent 0.
- **Fairness.** Both requesters valid continuously for 8 cycles with aOutReady=1 -> output tags 0,1,0,1,…; one output per cycle after 2-cycle fill; no requester starved.
- **Backpressure.** Stream from requester 1 with aOutReady low for 5 cycles:
  - exactly 2 items are accepted, then anReqReady=0;
  - outputs hold stable;
  - after release, order and values are preserved with no loss or duplication.
- **Reset mid-flight.** Assert aReset for 1 cycle with 2 items in flight -> anOutValid=0 the next cycle, rr=0, and the neither in-flight item ever appears at the output.

Source files
------------

// File: rtl/fp_normalize_arbiter.sv
// Round-robin arbiter feeding a shared leading-zero-detect and left-shift normalizer.
// Latency: 2 cycles from request transfer to result (S1 register, then S2 register).
// Backpressure: S2 holds while aOutReady is low, S1 holds behind it, and grants stop once both are full.
module fp_normalize_arbiter #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 8,
  parameter int NUM_REQ   = 2,
  parameter int TAG_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          aClock,
  input  logic                          aReset,
  input  logic [NUM_REQ-1:0]            aReqValid,
  input  logic [NUM_REQ*WIDTH-1:0]      aReqMantissa,
  input  logic [NUM_REQ*EXP_WIDTH-1:0]  aReqExponent,
  output logic [NUM_REQ-1:0]            anReqReady,
  output logic                          anOutValid,
  input  logic                          aOutReady,
  output logic [WIDTH-1:0]              anOutMantissa,
  output logic [EXP_WIDTH-1:0]          anOutExponent,
  output logic                          anOutZero,
  output logic [TAG_WIDTH-1:0]          anOutTag
);

  // lzc spans 0..WIDTH, so it needs one bit more than log2(WIDTH)
  localparam int LZW = $clog2(WIDTH) + 1;
  localparam int CW  = (LZW > EXP_WIDTH) ? LZW : EXP_WIDTH;

  logic [TAG_WIDTH-1:0] rr_q, rr_d;
  logic                 s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0]     s1_mant_q, s1_mant_d;
  logic [EXP_WIDTH-1:0] s1_exp_q, s1_exp_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
  logic                 s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0]     s2_mant_q, s2_mant_d;
  logic [EXP_WIDTH-1:0] s2_exp_q, s2_exp_d;
  logic                 s2_zero_q, s2_zero_d;
  logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;

  logic [NUM_REQ-1:0]   grant;
  logic [TAG_WIDTH-1:0] grant_idx;
  logic                 grant_any;
  logic                 s1_can_load;
  logic                 s1_load;
  logic                 s2_load;
  logic [LZW-1:0]       lzc;
  logic [LZW-1:0]       shift_amt;
  logic [WIDTH-1:0]     norm_mant;
  logic [EXP_WIDTH-1:0] norm_exp;
  logic                 norm_zero;

  // Round-robin search: first valid requester starting at rr and wrapping
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && (i == idx) && aReqValid[i]) begin
          grant[i]  = 1'b1;
          grant_idx = TAG_WIDTH'(i);
          grant_any = 1'b1;
        end
      end
    end
  end

  // Pipeline advance: S2 drains on consumer ready, S1 moves into an empty or draining S2
  always_comb begin
    s2_load     = s1_vld_q & (~s2_vld_q | aOutReady);
    s1_can_load = (~s1_vld_q | s2_load) & ~aReset;
    s1_load     = grant_any & s1_can_load;
    anReqReady  = s1_can_load ? grant : '0;
  end

  // Leading-zero count of the S1 mantissa; all-zero input gives WIDTH
  always_comb begin
    logic lz_found;
    lzc      = LZW'(WIDTH);
    lz_found = 1'b0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      if (!lz_found && s1_mant_q[b]) begin
        lzc      = LZW'(WIDTH - 1 - b);
        lz_found = 1'b1;
      end
    end
  end

  // Normalize: shift by lzc unless that would push the exponent below zero, then clamp at zero
  always_comb begin
    shift_amt = '0;
    norm_exp  = '0;
    norm_zero = 1'b0;
    if (lzc == LZW'(WIDTH)) begin
      norm_zero = 1'b1;
    end else if (CW'(lzc) < CW'(s1_exp_q)) begin
      shift_amt = lzc;
      norm_exp  = s1_exp_q - EXP_WIDTH'(lzc);
    end else begin
      // exponent <= lzc <= WIDTH-1 here, so it fits the shift width
      shift_amt = LZW'(s1_exp_q);
    end
    norm_mant = norm_zero ? '0 : (s1_mant_q << shift_amt);
  end

  // Next-state for arbitration pointer and both pipeline stages
  always_comb begin
    rr_d      = rr_q;
    s1_mant_d = s1_mant_q;
    s1_exp_d  = s1_exp_q;
    s1_tag_d  = s1_tag_q;
    s2_mant_d = s2_mant_q;
    s2_exp_d  = s2_exp_q;
    s2_zero_d = s2_zero_q;
    s2_tag_d  = s2_tag_q;
    if (s1_load) begin
      rr_d     = (grant_idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_WIDTH'(1);
      s1_tag_d = grant_idx;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          s1_mant_d = aReqMantissa[i*WIDTH +: WIDTH];
          s1_exp_d  = aReqExponent[i*EXP_WIDTH +: EXP_WIDTH];
        end
      end
    end
    if (s2_load) begin
      s2_mant_d = norm_mant;
      s2_exp_d  = norm_exp;
      s2_zero_d = norm_zero;
      s2_tag_d  = s1_tag_q;
    end
    s1_vld_d = s1_load | (s1_vld_q & ~s2_load);
    s2_vld_d = s2_load | (s2_vld_q & ~aOutReady);
  end

  // State registers; reset drops anything in flight
  always_ff @(posedge aClock) begin
    if (aReset) begin
      rr_q      <= '0;
      s1_vld_q  <= 1'b0;
      s1_mant_q <= '0;
      s1_exp_q  <= '0;
      s1_tag_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_mant_q <= '0;
      s2_exp_q  <= '0;
      s2_zero_q <= 1'b0;
      s2_tag_q  <= '0;
    end else begin
      rr_q      <= rr_d;
      s1_vld_q  <= s1_vld_d;
      s1_mant_q <= s1_mant_d;
      s1_exp_q  <= s1_exp_d;
      s1_tag_q  <= s1_tag_d;
      s2_vld_q  <= s2_vld_d;
      s2_mant_q <= s2_mant_d;
      s2_exp_q  <= s2_exp_d;
      s2_zero_q <= s2_zero_d;
      s2_tag_q  <= s2_tag_d;
    end
  end

  assign anOutValid    = s2_vld_q;
  assign anOutMantissa = s2_mant_q;
  assign anOutExponent = s2_exp_q;
  assign anOutZero     = s2_zero_q;
  assign anOutTag      = s2_tag_q;

endmodule

// File: tb/tb_fp_normalize_arbiter.sv
// Bench for fp_normalize_arbiter: random and directed requests, scoreboard of expected results.
// Expected results come from a shift-until-normalized-or-exponent-zero reference model.
// A negedge monitor checks grants, readiness, held outputs, values, order and latency.
module tb_fp_normalize_arbiter;
  localparam int W = 32;
  localparam int E = 8;
  localparam int N = 2;
  localparam int T = 1;

  typedef struct packed {
    logic [W-1:0] m;
    logic [E-1:0] e;
  } req_t;

  typedef struct packed {
    logic [W-1:0] m;
    logic [E-1:0] e;
    logic         z;
    logic [T-1:0] tag;
    logic [31:0]  acc;
  } exp_t;

  logic            aClock;
  logic            aReset;
  logic [N-1:0]    aReqValid;
  logic [N*W-1:0]  aReqMantissa;
  logic [N*E-1:0]  aReqExponent;
  logic [N-1:0]    anReqReady;
  logic            anOutValid;
  logic            aOutReady;
  logic [W-1:0]    anOutMantissa;
  logic [E-1:0]    anOutExponent;
  logic            anOutZero;
  logic [T-1:0]    anOutTag;

  fp_normalize_arbiter #(.WIDTH(W), .EXP_WIDTH(E), .NUM_REQ(N), .TAG_WIDTH(T)) dut (
    .aClock(aClock), .aReset(aReset), .aReqValid(aReqValid),
    .aReqMantissa(aReqMantissa), .aReqExponent(aReqExponent),
    .anReqReady(anReqReady), .anOutValid(anOutValid), .aOutReady(aOutReady),
    .anOutMantissa(anOutMantissa), .anOutExponent(anOutExponent),
    .anOutZero(anOutZero), .anOutTag(anOutTag)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t sb[$];
  req_t src0[$];
  req_t src1[$];
  logic [T-1:0] out_tags[$];

  logic [N-1:0] acc_flag = '0;
  int accs = 0;
  int outs = 0;
  int last_pop_edge = 0;
  logic [W-1:0] last_m;
  logic [E-1:0] last_e;
  logic         last_z;
  logic [T-1:0] last_tag;

  int unsigned vld_prob = 100;
  int unsigned rdy_prob = 100;
  bit rdy_rand = 1'b0;
  bit rdy_force = 1'b0;

  initial begin
    aClock = 1'b0;
    forever #5 aClock = ~aClock;
  end

  initial forever begin
    @(posedge aClock);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: walk the mantissa left one bit at a time while the top bit is clear
  // and there is exponent left to spend.
  function automatic exp_t model(input logic [W-1:0] m_in, input logic [E-1:0] e_in,
                                 input int tag, input int acc);
    exp_t r;
    logic [W-1:0] m;
    logic [E-1:0] e;
    m = m_in;
    e = e_in;
    if (m == '0) begin
      r.m = '0;
      r.e = '0;
      r.z = 1'b1;
    end else begin
      while (m[W-1] == 1'b0 && e != '0) begin
        m = m << 1;
        e = e - 1'b1;
      end
      r.m = m;
      r.e = e;
      r.z = 1'b0;
    end
    r.tag = T'(tag);
    r.acc = 32'(acc);
    return r;
  endfunction

  // Monitor / scoreboard
  initial begin
    int rr_m;
    int last_stall;
    bit prev_hold;
    bit post_rst;
    logic [N-1:0] g;
    logic [N-1:0] exp_rdy;
    exp_t x;
    rr_m = 0;
    last_stall = -10;
    prev_hold = 1'b0;
    post_rst = 1'b0;
    forever begin
      @(negedge aClock);
      if (aReset) begin
        check("ready_in_reset", 64'(anReqReady), 64'(0));
        sb.delete();
        rr_m = 0;
        acc_flag = '0;
        prev_hold = 1'b0;
        post_rst = 1'b1;
      end else begin
        if (post_rst) begin
          check("valid_after_reset", 64'(anOutValid), 64'(0));
          post_rst = 1'b0;
        end
        if (prev_hold) check("hold_valid", 64'(anOutValid), 64'(1));
        g = '0;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (rr_m + k) % N;
          if (g == '0 && aReqValid[idx]) g = N'(1) << idx;
        end
        exp_rdy = (g != '0 && (sb.size() < 2 || aOutReady)) ? g : '0;
        check("req_ready", 64'(anReqReady), 64'(exp_rdy));
        if (anOutValid) begin
          if (sb.size() == 0) begin
            check("spurious_out", 64'(anOutValid), 64'(0));
          end else begin
            x = sb[0];
            check("out_mant", 64'(anOutMantissa), 64'(x.m));
            check("out_exp", 64'(anOutExponent), 64'(x.e));
            check("out_zero", 64'(anOutZero), 64'(x.z));
            check("out_tag", 64'(anOutTag), 64'(x.tag));
            if (aOutReady) begin
              void'(sb.pop_front());
              if (last_stall < int'(x.acc) - 1)
                check("latency", 64'(cyc + 1 - int'(x.acc)), 64'(2));
              outs++;
              out_tags.push_back(anOutTag);
              last_m = anOutMantissa;
              last_e = anOutExponent;
              last_z = anOutZero;
              last_tag = anOutTag;
              last_pop_edge = cyc + 1;
            end
          end
        end
        prev_hold = anOutValid & ~aOutReady;
        acc_flag = '0;
        for (int i = 0; i < N; i++) begin
          if (aReqValid[i] && anReqReady[i]) begin
            sb.push_back(model(aReqMantissa[i*W +: W], aReqExponent[i*E +: E], i, cyc + 1));
            rr_m = (i + 1) % N;
            acc_flag[i] = 1'b1;
            accs++;
          end
        end
        if (!aOutReady) last_stall = cyc;
      end
    end
  end

  task automatic push(input int i, input logic [W-1:0] m, input logic [E-1:0] e);
    req_t r;
    r.m = m;
    r.e = e;
    if (i == 0) src0.push_back(r);
    else src1.push_back(r);
  endtask

  task automatic push_rand(input int i);
    logic [W-1:0] m;
    logic [E-1:0] e;
    if ($urandom_range(9) == 0) m = '0;
    else m = $urandom >> $urandom_range(W - 1);
    if ($urandom_range(1) == 1) e = E'($urandom_range(40));
    else e = E'($urandom);
    push(i, m, e);
  endtask

  // One clock: requesters keep valid/data until their transfer, then offer the next item
  task automatic step();
    req_t r;
    @(posedge aClock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_flag[i]) aReqValid[i] = 1'b0;
      if (!aReqValid[i] && ((i == 0) ? src0.size() : src1.size()) > 0 &&
          $urandom_range(99) < vld_prob) begin
        if (i == 0) r = src0.pop_front();
        else r = src1.pop_front();
        aReqMantissa[i*W +: W] = r.m;
        aReqExponent[i*E +: E] = r.e;
        aReqValid[i] = 1'b1;
      end
    end
    aOutReady = rdy_rand ? ($urandom_range(99) < rdy_prob) : rdy_force;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (!(src0.size() == 0 && src1.size() == 0 && aReqValid == '0 && sb.size() == 0)
           && n < budget) begin
      step();
      n++;
    end
    check({"drain_", name}, 64'(src0.size() + src1.size() + sb.size() + int'(aReqValid != '0)), 64'(0));
  endtask

  task automatic run_one(input int i, input logic [W-1:0] m, input logic [E-1:0] e);
    push(i, m, e);
    drain("single", 50);
  endtask

  initial begin
    int c0;
    int o0;
    int a0;
    aReset = 1'b1;
    aReqValid = '0;
    aReqMantissa = '0;
    aReqExponent = '0;
    aOutReady = 1'b0;
    repeat (3) step();
    check("rst_valid", 64'(anOutValid), 64'(0));
    check("rst_mant", 64'(anOutMantissa), 64'(0));
    check("rst_exp", 64'(anOutExponent), 64'(0));
    check("rst_zero", 64'(anOutZero), 64'(0));
    check("rst_tag", 64'(anOutTag), 64'(0));
    check("rst_ready", 64'(anReqReady), 64'(0));
    aReset = 1'b0;
    rdy_force = 1'b1;
    step();

    run_one(0, 32'h0000_1000, 8'd100);
    check("norm_mant", 64'(last_m), 64'h8000_0000);
    check("norm_exp", 64'(last_e), 64'd81);
    check("norm_zero", 64'(last_z), 64'd0);
    check("norm_tag", 64'(last_tag), 64'd0);

    run_one(1, 32'h0000_0001, 8'd10);
    check("clamp_mant", 64'(last_m), 64'h0000_0400);
    check("clamp_exp", 64'(last_e), 64'd0);
    check("clamp_zero", 64'(last_z), 64'd0);
    check("clamp_tag", 64'(last_tag), 64'd1);

    run_one(0, 32'h0000_0001, 8'd0);
    check("exp0_mant", 64'(last_m), 64'h0000_0001);
    check("exp0_exp", 64'(last_e), 64'd0);
    check("exp0_zero", 64'(last_z), 64'd0);

    run_one(1, 32'h0000_0000, 8'd55);
    check("zero_mant", 64'(last_m), 64'd0);
    check("zero_exp", 64'(last_e), 64'd0);
    check("zero_flag", 64'(last_z), 64'd1);

    // Fairness: both requesters continuously valid, consumer always ready
    for (int k = 0; k < 8; k++) begin
      push_rand(0);
      push_rand(1);
    end
    o0 = outs;
    step();
    c0 = cyc;
    drain("fair", 60);
    check("fair_count", 64'(outs - o0), 64'd16);
    check("fair_throughput", 64'(last_pop_edge - c0), 64'd18);
    for (int j = 0; j < 16; j++) begin
      if (o0 + j < out_tags.size()) check("fair_tag", 64'(out_tags[o0 + j]), 64'(j % 2));
    end

    // Backpressure: consumer stalls with requester 1 streaming
    rdy_force = 1'b0;
    a0 = accs;
    for (int k = 0; k < 6; k++) push_rand(1);
    repeat (5) step();
    check("bp_accepted", 64'(accs - a0), 64'd2);
    check("bp_ready_zero", 64'(anReqReady), 64'd0);
    rdy_force = 1'b1;
    o0 = outs;
    drain("bp", 60);
    check("bp_count", 64'(outs - o0), 64'd6);

    // Reset with two items in flight from requester 0
    rdy_force = 1'b0;
    a0 = accs;
    for (int k = 0; k < 4; k++) push_rand(0);
    repeat (4) step();
    check("mid_accepted", 64'(accs - a0), 64'd2);
    aReset = 1'b1;
    src0.delete();
    aReqValid = '0;
    step();
    aReset = 1'b0;
    check("mid_rst_valid", 64'(anOutValid), 64'd0);
    rdy_force = 1'b1;
    o0 = outs;
    push_rand(0);
    push_rand(1);
    drain("mid", 60);
    check("mid_count", 64'(outs - o0), 64'd2);
    if (out_tags.size() >= o0 + 2) begin
      check("mid_first_tag", 64'(out_tags[o0]), 64'd0);
      check("mid_second_tag", 64'(out_tags[o0 + 1]), 64'd1);
    end

    // Random traffic with random consumer stalls
    rdy_rand = 1'b1;
    rdy_prob = 65;
    vld_prob = 50;
    o0 = outs;
    for (int k = 0; k < 60; k++) begin
      push_rand(0);
      push_rand(1);
    end
    drain("random", 3000);
    check("random_count", 64'(outs - o0), 64'd120);
    rdy_rand = 1'b0;
    repeat (3) step();
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
